// File: rtl/nextpc_pkg.sv
// Shared types for the next-PC unit: FSM states and next-PC source select.
package nextpc_pkg;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} pc_state_t;

  typedef enum logic [2:0] {SRC_HOLD, SRC_SEQ, SRC_REL, SRC_REG, SRC_RAS} pc_src_t;

endpackage

// File: rtl/nextpc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module nextpc_ras #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] pushAddr,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [RAS_DEPTH-1:0][ADDR_W-1:0] mem;
  logic [PTR_W-1:0]                 ptr, ptrTop;
  logic [CNT_W-1:0]                 cnt;
  logic                             doPop;

  // ptr is the next write slot; depth is a power of two so it wraps for free
  assign ptrTop = ptr - PTR_W'(1);
  assign top    = mem[ptrTop];
  assign empty  = (cnt == '0);
  assign full   = (cnt == CNT_W'(RAS_DEPTH));
  assign doPop  = pop && !empty;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mem <= '0;
      ptr <= '0;
      cnt <= '0;
    end else if (doPop && push) begin
      mem[ptrTop] <= pushAddr;
    end else if (doPop) begin
      ptr <= ptrTop;
      cnt <= cnt - CNT_W'(1);
    end else if (push) begin
      mem[ptr] <= pushAddr;
      ptr      <= ptr + PTR_W'(1);
      if (!full) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// PC register with next-PC selection, boot/halt FSM and stall.
// Optional return-address stack enabled by defining NEXTPC_RAS_EN.
module next_pc_unit
  import nextpc_pkg::*;
#(
  parameter int              ADDR_W      = 64,
  parameter int              IMM_W       = 64,
  parameter int              INSTR_SHIFT = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH   = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              stall,
  input  logic              halt,
  input  logic [IMM_W-1:0]  imm,
  input  logic              branchCond,
  input  logic              condFlag,
  input  logic              uncondBranch,
  input  logic              regBranch,
  input  logic [ADDR_W-1:0] regTarget,
  input  logic              isCall,
  input  logic              isRet,
  output logic [ADDR_W-1:0] currentPC,
  output logic [ADDR_W-1:0] nextPC,
  output logic              branchTaken,
  output logic              misaligned
);

  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(1) << INSTR_SHIFT;
  localparam logic [ADDR_W-1:0] LOW_MASK = STEP - ADDR_W'(1);

  pc_state_t         state, stateNext;
  pc_src_t           src;
  logic              active, load;
  logic [ADDR_W-1:0] seqPC, relPC, rasTop;
  logic              rasEmpty;

  assign active = (state == RUN) && !stall;
  // halt freezes the PC on the edge that enters HALTED
  assign load   = active && !halt;
  assign seqPC  = currentPC + STEP;
  assign relPC  = currentPC + (ADDR_W'($signed(imm)) << INSTR_SHIFT);

`ifdef NEXTPC_RAS_EN
  nextpc_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) uRas (
    .CLK      (CLK),
    .Reset    (Reset),
    .push     (load && isCall),
    .pop      (load && isRet),
    .pushAddr (seqPC),
    .top      (rasTop),
    .empty    (rasEmpty),
    .full     ()
  );
`else
  localparam int unusedRasDepth = RAS_DEPTH;
  logic unusedIsCall;
  assign unusedIsCall = isCall;
  assign rasTop       = '0;
  assign rasEmpty     = 1'b1;
`endif

  always_comb begin
    src = SRC_HOLD;
    if (active) begin
      if (isRet && !rasEmpty)                src = SRC_RAS;
      else if (regBranch || isRet)           src = SRC_REG;
      else if (uncondBranch)                 src = SRC_REL;
      else if (branchCond && condFlag)       src = SRC_REL;
      else                                   src = SRC_SEQ;
    end
  end

  always_comb begin
    nextPC = currentPC;
    unique case (src)
      SRC_SEQ: nextPC = seqPC;
      SRC_REL: nextPC = relPC;
      SRC_REG: nextPC = regTarget;
      SRC_RAS: nextPC = rasTop;
      default: nextPC = currentPC;
    endcase
  end

  assign branchTaken = (src != SRC_HOLD) && (src != SRC_SEQ);

  always_comb begin
    stateNext = state;
    unique case (state)
      BOOT:    stateNext = RUN;
      RUN:     if (halt) stateNext = HALTED;
      HALTED:  stateNext = HALTED;
      default: stateNext = BOOT;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= BOOT;
      currentPC  <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      state <= stateNext;
      if (load) begin
        currentPC  <= nextPC;
        misaligned <= |(nextPC & LOW_MASK);
      end
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: expected PC/misaligned queued at drive, checked after the edge.
module tb_next_pc_unit;

  localparam logic [63:0] RPC = 64'h1000;

  logic        CLK, Reset, stall, halt, branchCond, condFlag, uncondBranch;
  logic        regBranch, isCall, isRet;
  logic [63:0] imm, regTarget;
  logic [63:0] currentPC, nextPC;
  logic        branchTaken, misaligned;

  typedef struct packed {
    logic [63:0] pc;
    logic        mis;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  next_pc_unit #(.ADDR_W(64), .IMM_W(64), .INSTR_SHIFT(2), .RESET_PC(RPC), .RAS_DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset), .stall(stall), .halt(halt), .imm(imm),
    .branchCond(branchCond), .condFlag(condFlag), .uncondBranch(uncondBranch),
    .regBranch(regBranch), .regTarget(regTarget), .isCall(isCall), .isRet(isRet),
    .currentPC(currentPC), .nextPC(nextPC), .branchTaken(branchTaken), .misaligned(misaligned)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    stall = 0; halt = 0; imm = '0; branchCond = 0; condFlag = 0;
    uncondBranch = 0; regBranch = 0; regTarget = '0; isCall = 0; isRet = 0;
  endtask

  // Inputs are already driven (after a negedge). Check comb outputs, queue the
  // post-edge expectation, then compare it after the rising edge.
  task automatic cyc(input string tag, input logic [63:0] eNext, input logic eTaken,
                     input logic [63:0] ePC, input logic eMis, input bit comb = 1);
    exp_t e;
    #1;
    if (comb) begin
      chk({tag, "_nxt"}, nextPC, eNext);
      chk({tag, "_tkn"}, 64'(branchTaken), 64'(eTaken));
    end
    sbq.push_back('{pc: ePC, mis: eMis});
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    chk({tag, "_pc"}, currentPC, e.pc);
    chk({tag, "_mis"}, 64'(misaligned), 64'(e.mis));
    @(negedge CLK);
  endtask

  task automatic goTo(input logic [63:0] a);
    clr(); regBranch = 1; regTarget = a;
    cyc("goto", a, 1, a, |a[1:0]);
  endtask

  initial begin
    CLK = 0; Reset = 1; clr();
    #1;
    chk("rst_pc", currentPC, RPC);
    chk("rst_mis", 64'(misaligned), 64'd0);
    chk("rst_nxt", nextPC, RPC);
    chk("rst_tkn", 64'(branchTaken), 64'd0);
    @(negedge CLK); Reset = 0;

    // boot holds, then sequential step
    cyc("boot", RPC, 0, RPC, 0);
    cyc("seq", 64'h1004, 0, 64'h1004, 0);

    // conditional branch taken / not taken
    goTo(64'h1000);
    clr(); branchCond = 1; condFlag = 1; imm = 64'd2;
    cyc("bc_t", 64'h1008, 1, 64'h1008, 0);
    goTo(64'h1000);
    clr(); branchCond = 1; condFlag = 0; imm = 64'd2;
    cyc("bc_nt", 64'h1004, 0, 64'h1004, 0);

    // negative offset and wraparound
    goTo(64'h1000);
    clr(); uncondBranch = 1; imm = -64'd4;
    cyc("ub_neg", 64'h0FF0, 1, 64'h0FF0, 0);
    goTo(64'hFFFF_FFFF_FFFF_FFFC);
    clr();
    cyc("wrap", 64'h0, 0, 64'h0, 0);

    // stall ignores branches
    clr(); stall = 1; uncondBranch = 1; imm = 64'd3;
    cyc("stall", 64'h0, 0, 64'h0, 0);
    clr(); uncondBranch = 1; imm = 64'd3;
    cyc("ub_pos", 64'hC, 1, 64'hC, 0);

    // register-indirect, misaligned, priority over uncond
    clr(); regBranch = 1; regTarget = 64'h2002;
    cyc("reg_mis", 64'h2002, 1, 64'h2002, 1);
    clr(); regBranch = 1; regTarget = 64'h3000; uncondBranch = 1; imm = 64'd5;
    cyc("reg_pri", 64'h3000, 1, 64'h3000, 0);
    // return with nothing stacked goes to regTarget
    clr(); isRet = 1; regTarget = 64'h4000;
    cyc("ret_reg", 64'h4000, 1, 64'h4000, 0);

`ifdef NEXTPC_RAS_EN
    goTo(64'h1000);
    for (int i = 0; i < 5; i++) begin
      clr(); isCall = 1; regBranch = 1; regTarget = 64'h1010 + 64'(i) * 64'h10;
      cyc("call", regTarget, 1, regTarget, 0);
    end
    // oldest entry (0x1004) was overwritten by the fifth call
    for (int i = 0; i < 4; i++) begin
      clr(); isRet = 1; regTarget = 64'h5000;
      cyc("ret_ras", 64'h1044 - 64'(i) * 64'h10, 1, 64'h1044 - 64'(i) * 64'h10, 0);
    end
    clr(); isRet = 1; regTarget = 64'h5000;
    cyc("ret_empty", 64'h5000, 1, 64'h5000, 0);
    clr(); isCall = 1; regBranch = 1; regTarget = 64'h6000;
    cyc("call2", 64'h6000, 1, 64'h6000, 0);
    clr(); isCall = 1; isRet = 1; regTarget = 64'h7000;
    cyc("callret", 64'h5004, 1, 64'h5004, 0);
    clr(); isRet = 1; regTarget = 64'h7000;
    cyc("ret_repl", 64'h6004, 1, 64'h6004, 0);
    clr(); isRet = 1; regTarget = 64'h7000;
    cyc("ret_empty2", 64'h7000, 1, 64'h7000, 0);
`endif

    // async reset mid-run, no clock edge needed
    clr();
    #2 Reset = 1;
    #1;
    chk("arst_pc", currentPC, RPC);
    chk("arst_nxt", nextPC, RPC);
    @(negedge CLK); Reset = 0;
    cyc("boot2", RPC, 0, RPC, 0);
    cyc("seq2", 64'h1004, 0, 64'h1004, 0);

    // halt freezes the PC until reset
    clr(); halt = 1;
    cyc("halt", 64'h0, 0, 64'h1004, 0, 0);
    clr(); uncondBranch = 1; imm = 64'd8;
    cyc("halted_ub", 64'h1004, 0, 64'h1004, 0);
    clr(); regBranch = 1; regTarget = 64'h9000;
    cyc("halted_reg", 64'h1004, 0, 64'h1004, 0);
    clr();
    #2 Reset = 1;
    #1;
    chk("hrst_pc", currentPC, RPC);
    @(negedge CLK); Reset = 0;
    cyc("boot3", RPC, 0, RPC, 0);
    cyc("seq3", 64'h1004, 0, 64'h1004, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
